mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for the supported opcodes.
- Drives the PC update enable, which combines the unconditional PC write with the Branch/Zero condition.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instr_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  6  instruction bits [31:26], taken from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC register load enable.
- PCWrite  out  1  unconditional PC write.
- Branch  out  1  conditional PC write (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  unsupported opcode detected.
- state  out  4  current state (debug).
- instr_count  out  CNT_W  retired legal instructions.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIWB=10.
  - Codes 11-15 are illegal states: all outputs 0, next state FETCH.
- Reset:
  - While rst=1: next state FETCH and instr_count <= 0.
  - All control outputs are forced to 0 combinationally, so no memory or register write occurs during reset.
  - Reset mid-instruction aborts it with no writeback and no count increment.
  - First cycle after rst drops: state=FETCH.
- Outputs are a function of state only, except FETCH/MEMRD/MEMWR gating on mem_ready and pc_en on Zero. Unlisted outputs are 0 in each state.
- FETCH:
  - MemRead=1, ALUSrcB=01.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcB=11. Next state by opcode:
  - 000000 -> EXEC
  - 100011 (lw), 101011 (sw), 001000 (addi) -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode: illegal=1 for this cycle, next state FETCH, no count.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state: lw -> MEMRD, sw -> MEMWR, addi -> ADDIWB.
- MEMRD: IorD=1, MemRead=1. Stays until mem_ready=1, then goes to MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0. Next state FETCH.
- MEMWR:
  - IorD=1, MemWrite=1.
  - MemWrite stays asserted until mem_ready=1, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state FETCH.
- ADDIWB: RegDst=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, Branch=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- pc_en = PCWrite | (Branch & Zero). In BRANCH, pc_en is asserted only when Zero=1.
- instr_count:
  - Increments by 1 on each clock edge where the state is MEMWB, MEMWR (with mem_ready=1), ALUWB, ADDIWB, BRANCH or JUMP.
  - Wraps modulo 2^CNT_W.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- opcode is sampled in DECODE and MEMADR only; it must be stable from DECODE onward.

Test Plan:
- rst=1 for 2 cycles, then release -> all outputs 0 during reset; state=0, instr_count=0 on the first cycle after release.
- R-type (000000), mem_ready=1 -> states 0,1,6,7,0. In EXEC: ALUOp=10. In ALUWB: RegWrite=1, RegDst=1. instr_count=1.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with IorD=1, MemRead=1. Then MEMWB with MemtoReg=1; total 7 cycles.
- beq (000100) with Zero=0, then again with Zero=1 -> in BRANCH: Branch=1 both times, pc_en 0 then 1, PCSource=01.
- j (000010) then opcode 111111 -> JUMP: pc_en=1, PCSource=10. Illegal opcode: DECODE illegal=1, back to FETCH, instr_count unchanged.
- sw (101011) with rst asserted in MEMWR -> MemWrite drops to 0 in the same cycle. State=FETCH and instr_count=0 on the next edge.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready and counts retired instructions.
module mips_multicycle_control #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             PCWrite,
   output logic             Branch,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIWB = 4'd10
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire_c;

   // State register
   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   // Next-state logic; undefined codes fall back to FETCH
   always_comb begin
      state_d = FETCH;
      if (!rst) begin
         case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
               case (opcode)
                  OP_RTYPE:               state_d = EXEC;
                  OP_LW, OP_SW, OP_ADDI:  state_d = MEMADR;
                  OP_BEQ:                 state_d = BRANCH;
                  OP_J:                   state_d = JUMP;
                  default:                state_d = FETCH;
               endcase
            end
            MEMADR: begin
               case (opcode)
                  OP_LW:   state_d = MEMRD;
                  OP_SW:   state_d = MEMWR;
                  OP_ADDI: state_d = ADDIWB;
                  default: state_d = FETCH;
               endcase
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXEC:    state_d = ALUWB;
            default: state_d = FETCH;
         endcase
      end
   end

   // Control outputs; everything held low while rst is asserted
   always_comb begin
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSource = 2'b00;
      illegal  = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            DECODE: begin
               ALUSrcB = 2'b11;
               illegal = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J});
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEMRD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
            end
            MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
               ALUSrcA  = 1'b1;
               ALUOp    = 2'b01;
               Branch   = 1'b1;
               PCSource = 2'b01;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            default: ;
         endcase
      end
      pc_en = PCWrite | (Branch & Zero);
   end

   // An instruction retires on the edge that leaves its final state
   assign retire_c = (state_q inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP}) ||
                     ((state_q == MEMWR) && mem_ready);

   always_comb begin
      cnt_d = cnt_q;
      if (rst) begin
         cnt_d = '0;
      end else if (retire_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule
